// File: rtl/demux_memoria_valid.sv
// Registered 1-to-2 demultiplexer: each valid word is steered to one lane, which
// holds the word, pulses its valid for one cycle and counts the delivery.
module demux_memoria_valid #(
  parameter int BW = 2,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic [BW-1:0] data_in,
  input  logic          valid_in,
  input  logic          selector,
  input  logic          auto_sel,
  output logic [BW-1:0] data_out0,
  output logic [BW-1:0] data_out1,
  output logic          valid_out0,
  output logic          valid_out1,
  output logic          lane_ptr,
  output logic [CW-1:0] count0,
  output logic [CW-1:0] count1
);

  logic [BW-1:0] r_data0, r_data1;
  logic          r_vld0, r_vld1;
  logic          r_ptr;
  logic [CW-1:0] r_cnt0, r_cnt1;
  logic          w_lane;

  // Auto mode replays the stored pointer so interleaving resumes where it left off.
  assign w_lane = auto_sel ? r_ptr : selector;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_data0 <= '0;
      r_data1 <= '0;
      r_vld0  <= 1'b0;
      r_vld1  <= 1'b0;
      r_ptr   <= 1'b0;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
    end else begin
      // Gating by valid_in keeps an unknown lane/data from leaking when idle.
      r_vld0 <= valid_in & ~w_lane;
      r_vld1 <= valid_in &  w_lane;
      if (valid_in) begin
        if (w_lane) begin
          r_data1 <= data_in;
          r_cnt1  <= r_cnt1 + 1'b1;
        end else begin
          r_data0 <= data_in;
          r_cnt0  <= r_cnt0 + 1'b1;
        end
        if (auto_sel) r_ptr <= ~r_ptr;
      end
    end
  end

  assign data_out0  = r_data0;
  assign data_out1  = r_data1;
  assign valid_out0 = r_vld0;
  assign valid_out1 = r_vld1;
  assign lane_ptr   = r_ptr;
  assign count0     = r_cnt0;
  assign count1     = r_cnt1;

endmodule

// File: tb/tb_demux_memoria_valid.sv
// Directed bench for demux_memoria_valid (BW=2, CW=4) with hand-computed expectations.
module tb_demux_memoria_valid;

  logic       clk;
  logic       reset_L;
  logic [1:0] data_in;
  logic       valid_in;
  logic       selector;
  logic       auto_sel;
  logic [1:0] data_out0, data_out1;
  logic       valid_out0, valid_out1, lane_ptr;
  logic [3:0] count0, count1;

  int checks;
  int failures;

  demux_memoria_valid #(.BW(2), .CW(4)) dut (
    .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .selector(selector), .auto_sel(auto_sel),
    .data_out0(data_out0), .data_out1(data_out1),
    .valid_out0(valid_out0), .valid_out1(valid_out1), .lane_ptr(lane_ptr),
    .count0(count0), .count1(count1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] d0, input logic [1:0] d1,
                         input logic v0, input logic v1, input logic p,
                         input logic [3:0] c0, input logic [3:0] c1);
    chk({tag, ".data_out0"},  {30'd0, data_out0},  {30'd0, d0});
    chk({tag, ".data_out1"},  {30'd0, data_out1},  {30'd0, d1});
    chk({tag, ".valid_out0"}, {31'd0, valid_out0}, {31'd0, v0});
    chk({tag, ".valid_out1"}, {31'd0, valid_out1}, {31'd0, v1});
    chk({tag, ".lane_ptr"},   {31'd0, lane_ptr},   {31'd0, p});
    chk({tag, ".count0"},     {28'd0, count0},     {28'd0, c0});
    chk({tag, ".count1"},     {28'd0, count1},     {28'd0, c1});
  endtask

  // Apply inputs mid-cycle, then sample 1 time unit after the next rising edge.
  task automatic step(input logic v, input logic [1:0] d, input logic a, input logic s);
    valid_in = v;
    data_in  = d;
    auto_sel = a;
    selector = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_L  = 1'b0;
    valid_in = 1'b1;
    data_in  = 2'b11;
    auto_sel = 1'b1;
    selector = 1'b0;

    // Reset held while words are offered
    step(1'b1, 2'b11, 1'b1, 1'b0);
    step(1'b1, 2'b10, 1'b1, 1'b1);
    chk_all("reset_hold", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    reset_L = 1'b1;
    step(1'b1, 2'b01, 1'b1, 1'b0);
    chk_all("first_word", 2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 4'd1, 4'd0);
    step(1'b1, 2'b10, 1'b1, 1'b0);
    chk_all("realign", 2'd1, 2'd2, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1);

    // Auto de-interleave, lane_ptr starts at 0
    step(1'b1, 2'b01, 1'b1, 1'b0);
    chk_all("auto0", 2'd1, 2'd2, 1'b1, 1'b0, 1'b1, 4'd2, 4'd1);
    step(1'b1, 2'b10, 1'b1, 1'b0);
    chk_all("auto1", 2'd1, 2'd2, 1'b0, 1'b1, 1'b0, 4'd2, 4'd2);
    step(1'b1, 2'b11, 1'b1, 1'b0);
    chk_all("auto2", 2'd3, 2'd2, 1'b1, 1'b0, 1'b1, 4'd3, 4'd2);
    step(1'b1, 2'b00, 1'b1, 1'b0);
    chk_all("auto3", 2'd3, 2'd0, 1'b0, 1'b1, 1'b0, 4'd3, 4'd3);

    // Memory on invalid, including X data
    step(1'b1, 2'b11, 1'b0, 1'b1);
    chk_all("deliver11", 2'd3, 2'd3, 1'b0, 1'b1, 1'b0, 4'd3, 4'd4);
    step(1'b0, 2'b00, 1'b1, 1'b0);
    chk_all("idle0", 2'd3, 2'd3, 1'b0, 1'b0, 1'b0, 4'd3, 4'd4);
    step(1'b0, 2'bxx, 1'b1, 1'b1);
    chk_all("idle1_x", 2'd3, 2'd3, 1'b0, 1'b0, 1'b0, 4'd3, 4'd4);
    step(1'b0, 2'b01, 1'b0, 1'b1);
    chk_all("idle2", 2'd3, 2'd3, 1'b0, 1'b0, 1'b0, 4'd3, 4'd4);

    // Manual steering with pointer hold
    step(1'b1, 2'b10, 1'b1, 1'b1);
    chk_all("set_ptr1", 2'd2, 2'd3, 1'b1, 1'b0, 1'b1, 4'd4, 4'd4);
    step(1'b1, 2'b01, 1'b0, 1'b0);
    chk_all("man0", 2'd1, 2'd3, 1'b1, 1'b0, 1'b1, 4'd5, 4'd4);
    step(1'b1, 2'b10, 1'b0, 1'b0);
    chk_all("man1", 2'd2, 2'd3, 1'b1, 1'b0, 1'b1, 4'd6, 4'd4);
    step(1'b1, 2'b11, 1'b0, 1'b0);
    chk_all("man2", 2'd3, 2'd3, 1'b1, 1'b0, 1'b1, 4'd7, 4'd4);
    step(1'b1, 2'b01, 1'b0, 1'b0);
    chk_all("man3", 2'd1, 2'd3, 1'b1, 1'b0, 1'b1, 4'd8, 4'd4);
    step(1'b1, 2'b10, 1'b1, 1'b0);
    chk_all("auto_resume", 2'd1, 2'd2, 1'b0, 1'b1, 1'b0, 4'd8, 4'd5);

    // Counter wrap on lane 1: 5 + 16 words -> passes 15 -> 0, ends at 5
    for (int k = 0; k < 16; k++) begin
      logic [3:0] w_exp;
      logic [1:0] d_exp;
      w_exp = 4'(5 + k + 1);
      d_exp = 2'(k);
      step(1'b1, d_exp, 1'b0, 1'b1);
      chk_all($sformatf("wrap%0d", k), 2'd1, d_exp, 1'b0, 1'b1, 1'b0, 4'd8, w_exp);
    end
    step(1'b0, 2'b00, 1'b0, 1'b1);
    chk_all("wrap_end", 2'd1, 2'd3, 1'b0, 1'b0, 1'b0, 4'd8, 4'd5);

    // Async reset between edges during an auto stream
    step(1'b1, 2'b11, 1'b1, 1'b0);
    chk_all("pre_reset", 2'd3, 2'd3, 1'b1, 1'b0, 1'b1, 4'd9, 4'd5);
    valid_in = 1'b1;
    data_in  = 2'b10;
    #2;
    reset_L = 1'b0;
    #1;
    chk_all("async_reset", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    @(posedge clk);
    #1;
    chk_all("reset_edge", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    reset_L = 1'b1;
    step(1'b1, 2'b10, 1'b1, 1'b1);
    chk_all("post_reset", 2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 4'd1, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_memoria_valid.md
# demux_memoria_valid

Registered 1-to-2 demultiplexer with valid tracking and output memory. It is the receive-side counterpart of the team's mux-with-memory blocks: it takes a single valid-qualified data stream and steers each valid word to one of two lanes. Lane selection comes either from an external selector or from an internal alternating pointer that undoes 2:1 interleaving. Each lane holds its last delivered word and counts deliveries, so the stream can be re-split and checked against the original mux inputs.

## Interface
Parameters:
- BW, 2: data width in bits; legal 1..16.
- CW, 4: width of the per-lane delivery counters.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset_L  in  1  reset, asynchronous and active-low; clears all state immediately when low.
- data_in  in  BW  input word.
- valid_in  in  1  data_in is a real word this cycle.
- selector  in  1  external lane select (0 → lane 0, 1 → lane 1); used only when auto_sel=0.
- auto_sel  in  1  1: use the internal alternating pointer; 0: use selector.
- data_out0  out  BW  last word delivered to lane 0 (held).
- data_out1  out  BW  last word delivered to lane 1 (held).
- valid_out0  out  1  data_out0 was updated on the last edge.
- valid_out1  out  1  data_out1 was updated on the last edge.
- lane_ptr  out  1  internal pointer: the lane the next auto-mode word goes to.
- count0  out  CW  words delivered to lane 0, modulo 2^CW.
- count1  out  CW  words delivered to lane 1, modulo 2^CW.

## Operation
- Reset (reset_L=0, asynchronous): all outputs go to 0 — data_out0/1, valid_out0/1, lane_ptr, count0/1. They stay 0 while reset_L=0, regardless of clk.
- Lane choice: lane = auto_sel ? lane_ptr : selector, sampled at the clock edge.
- valid_in=1 at an edge:
  - data_out[lane] ← data_in; valid_out[lane] ← 1; count[lane] ← count[lane]+1.
  - The other lane: valid_out ← 0; data and count unchanged.
- valid_in=0 at an edge: both valid_out ← 0; all data, counts and lane_ptr unchanged (memory).
- lane_ptr update:
  - Toggles on an edge only when valid_in=1 and auto_sel=1.
  - In manual mode (auto_sel=0) it holds, so re-entering auto mode resumes from the stored lane.
- Counters wrap from 2^CW−1 to 0 with no flag. Only the selected lane's counter changes on a given edge.
- Both valid_out bits are never 1 in the same cycle.
- X/Z on data_in while valid_in=0 must not propagate to any output.

## Timing
- Latency is one cycle: a word accepted at edge N appears on data_out[lane] with valid_out[lane]=1 right after edge N. valid_out drops after edge N+1 unless another word goes to that lane at edge N+1.
- Throughput: one word per cycle. Back-to-back valid words in auto mode alternate lanes every cycle, so valid_out0 and valid_out1 toggle in antiphase.
- No backpressure: every valid word is accepted.
- Mode switch: a change of auto_sel or selector takes effect at the next edge. No settling cycle is required.
- Reset mid-stream: outputs clear as soon as reset_L falls, not at the next edge. After reset_L rises, the first valid word goes to lane 0 in auto mode (lane_ptr=0).
- reset_L is synchronized externally; deassertion near a clock edge is out of scope.

## Test plan
- Reset: drive words with reset_L=0 → all outputs stay 0. Release reset_L, send valid word 2'b01 with auto_sel=1 → data_out0=01, valid_out0=1, count0=1, lane_ptr=1.
- Auto de-interleave: send 01,10,11,00 back-to-back, valid, auto_sel=1 → lane 0 receives 01 then 11, lane 1 receives 10 then 00. valid_out0/valid_out1 alternate 1/0 each cycle. Final count0=count1=2, lane_ptr=0.
- Memory on invalid: deliver 11 to lane 1, then hold valid_in=0 for 3 cycles with data_in toggling → data_out1 stays 11, both valid_out=0, counts and lane_ptr unchanged.
- Manual steering and ptr hold: set lane_ptr=1, switch auto_sel=0 with selector=0, send 4 valid words → all go to lane 0, count0 rises by 4, lane_ptr stays 1. Return to auto_sel=1 → next word goes to lane 1.
- Counter wrap: with CW=4, send 16 valid words with selector=1 in manual mode → count1 goes 15→0, count0 unchanged.
- Async reset mid-stream: pull reset_L low between edges during an auto stream → all outputs are 0 before the next rising edge.
